// File: rtl/sc_fifo.sv
// Single-clock FIFO with flags decoded from a registered occupancy count; normal mode q is 1 cycle after rdreq, show-ahead q tracks the head word.
// No backpressure on the ports: a write while full or a read while empty is dropped unless checking is "OFF".
module sc_fifo #(
  parameter int    lpm_width               = 16,
  parameter int    lpm_widthu              = 2,
  parameter int    lpm_numwords            = 4,
  parameter string lpm_showahead           = "OFF",
  parameter string overflow_checking       = "ON",
  parameter string underflow_checking      = "ON",
  parameter int    almost_full_value       = lpm_numwords,
  parameter int    almost_empty_value      = 1,
  parameter string add_ram_output_register = "OFF",
  parameter string use_eab                 = "ON",
  parameter string ram_block_type          = "AUTO",
  parameter string enable_ecc              = "FALSE",
  parameter string lpm_type                = "scfifo"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  empty,
  output logic                  full,
  output logic [lpm_widthu-1:0] usedw,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [1:0]            eccstatus
);

  localparam int              PW        = (lpm_numwords > 1) ? $clog2(lpm_numwords) : 1;
  localparam int              CW        = lpm_widthu + 1;
  localparam bit              SHOWAHEAD = (lpm_showahead == "ON");
  localparam bit              OVF_CHK   = (overflow_checking == "ON");
  localparam bit              UNF_CHK   = (underflow_checking == "ON");
  localparam logic [PW-1:0]   LAST_PTR  = PW'(lpm_numwords - 1);
  localparam logic [CW-1:0]   DEPTH     = CW'(lpm_numwords);
  localparam logic [31:0]     AFV       = almost_full_value;
  localparam logic [31:0]     AEV       = almost_empty_value;

  if ((1 << lpm_widthu) < lpm_numwords) begin : g_bad_widthu
    $error("sc_fifo: lpm_widthu too small for lpm_numwords");
  end

  logic [lpm_width-1:0] mem_q [lpm_numwords];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [lpm_width-1:0] q_q, q_d;
  logic [lpm_width-1:0] head;
  logic                 empty_int, full_int, wr_acc, rd_acc;
  logic [31:0]          cnt_ext;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty_int = (cnt_q == '0);
    full_int  = (cnt_q == DEPTH);
    wr_acc    = wrreq && !(full_int && OVF_CHK);
    rd_acc    = rdreq && !(empty_int && UNF_CHK);
    head      = mem_q[rd_ptr_q];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      // Show-ahead q falls back to q_q once empty; capture the visible head so q does not change.
      if (SHOWAHEAD && !empty_int) q_d = head;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        q_d      = head;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!sclr && wr_acc) mem_q[wr_ptr_q] <= data;
  end

  assign cnt_ext      = 32'(cnt_q);
  assign q            = (SHOWAHEAD && !empty_int) ? head : q_q;
  assign empty        = empty_int;
  assign full         = full_int;
  assign usedw        = cnt_q[lpm_widthu-1:0];
  assign almost_full  = (cnt_ext >= AFV);
  assign almost_empty = (cnt_ext < AEV);
  assign eccstatus    = 2'b00;

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a normal-mode and a show-ahead instance share one stimulus stream.
module tb_sc_fifo;

  logic        clock, aclr, sclr, wrreq, rdreq;
  logic [15:0] data;
  logic [15:0] q, q_sa;
  logic        empty, full, almost_full, almost_empty;
  logic        empty_sa, full_sa, almost_full_sa, almost_empty_sa;
  logic [1:0]  usedw, usedw_sa, eccstatus, eccstatus_sa;

  int n_tests = 0;
  int n_fail  = 0;

  sc_fifo #(.lpm_width(16), .lpm_widthu(2), .lpm_numwords(4), .lpm_showahead("OFF")) dut (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .usedw(usedw), .almost_full(almost_full),
    .almost_empty(almost_empty), .eccstatus(eccstatus)
  );

  sc_fifo #(.lpm_width(16), .lpm_widthu(2), .lpm_numwords(4), .lpm_showahead("ON")) dut_sa (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_sa), .empty(empty_sa), .full(full_sa), .usedw(usedw_sa), .almost_full(almost_full_sa),
    .almost_empty(almost_empty_sa), .eccstatus(eccstatus_sa)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] fill_words [4];
  logic [1:0]  ops [10];
  logic [15:0] model [$];
  logic [15:0] last_q;
  logic [15:0] next_word;

  initial begin
    fill_words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    ops = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11};

    aclr = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_q", q, 0);
    chk("rst_q_sa", q_sa, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_ecc", eccstatus, 0);
    #9 aclr = 1'b1;

    // Fill to depth 4
    for (int i = 0; i < 4; i++) begin
      wrreq = 1'b1; data = fill_words[i];
      tick();
      chk("fill_usedw", usedw, (i + 1) % 4);
      chk("fill_empty", empty, 0);
      chk("fill_q_hold", q, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_almost_full", almost_full, 1);

    data = 16'h0055;
    tick();
    wrreq = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_usedw", usedw, 0);

    rdreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_q", q, fill_words[i]);
      chk("drain_usedw", usedw, 3 - i);
      chk("drain_empty", empty, (i == 3) ? 1 : 0);
    end

    tick();
    rdreq = 1'b0;
    chk("unf_q", q, 16'h0044);
    chk("unf_usedw", usedw, 0);
    chk("unf_empty", empty, 1);

    // Both requests while empty: only the write lands
    wrreq = 1'b1; rdreq = 1'b1; data = 16'h0066;
    tick();
    chk("both_empty_usedw", usedw, 1);
    chk("both_empty_q", q, 16'h0044);
    rdreq = 1'b0; data = 16'h0077;
    tick();
    chk("two_stored_usedw", usedw, 2);
    rdreq = 1'b1; data = 16'h0088;
    tick();
    wrreq = 1'b0;
    chk("both_two_usedw", usedw, 2);
    chk("both_two_q", q, 16'h0066);
    tick();
    chk("both_order_q1", q, 16'h0077);
    tick();
    rdreq = 1'b0;
    chk("both_order_q2", q, 16'h0088);
    chk("both_order_empty", empty, 1);

    // Asynchronous reset with two words stored
    wrreq = 1'b1; data = 16'h0099;
    tick();
    data = 16'h00AA;
    tick();
    wrreq = 1'b0;
    chk("pre_aclr_usedw", usedw, 2);
    #1 aclr = 1'b0;
    #1;
    chk("aclr_empty", empty, 1);
    chk("aclr_usedw", usedw, 0);
    chk("aclr_q", q, 0);
    #1 aclr = 1'b1;

    // Show-ahead instance exposes the word without rdreq
    wrreq = 1'b1; data = 16'hBEEF;
    tick();
    wrreq = 1'b0;
    chk("sa_empty_fall", empty_sa, 0);
    chk("sa_q_show", q_sa, 16'hBEEF);
    chk("norm_q_no_show", q, 0);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("sa_empty_after_rd", empty_sa, 1);
    chk("sa_q_hold", q_sa, 16'hBEEF);
    chk("norm_q_after_rd", q, 16'hBEEF);

    // Interleaved traffic that wraps both pointers
    last_q = 16'hBEEF;
    next_word = 16'h0100;
    wrreq = 1'b1; data = next_word;
    tick();
    wrreq = 1'b0;
    model.push_back(next_word);
    next_word++;
    for (int i = 0; i < 10; i++) begin
      wrreq = ops[i][1]; rdreq = ops[i][0]; data = next_word;
      tick();
      if (ops[i][0]) last_q = model.pop_front();
      if (ops[i][1]) begin
        model.push_back(next_word);
        next_word++;
      end
      chk("wrap_q", q, last_q);
      chk("wrap_usedw", usedw, model.size());
    end
    wrreq = 1'b0; rdreq = 1'b0;

    sclr = 1'b1; wrreq = 1'b1; data = 16'h0ABC;
    tick();
    sclr = 1'b0; wrreq = 1'b0;
    chk("sclr_empty", empty, 1);
    chk("sclr_usedw", usedw, 0);
    chk("sclr_q_hold", q, last_q);

    wrreq = 1'b1; data = 16'h01EE;
    tick();
    wrreq = 1'b0; rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("post_sclr_q", q, 16'h01EE);
    chk("post_sclr_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_fifo.md
# sc_fifo

Single-clock, parameterised first-in-first-out buffer with registered status flags. It supports a normal (read-latency) mode and a show-ahead mode. It is the storage primitive beneath the `fifo` wrapper in the credit-based latency-insensitive channels: the sender's credit counter prevents overflow, and the receiver pops data using `empty`. Storage is an inferred memory of `lpm_numwords` × `lpm_width` bits.

## Interface
- `lpm_width`, 16: data word width in bits.
- `lpm_widthu`, 2: width of `usedw`; must satisfy 2**`lpm_widthu` >= `lpm_numwords`.
- `lpm_numwords`, 4: depth in words.
- `lpm_showahead`, "OFF": "OFF" selects normal mode; "ON" selects show-ahead mode.
- `overflow_checking`, "ON": when "ON", writes while full are ignored.
- `underflow_checking`, "ON": when "ON", reads while empty are ignored.
- `almost_full_value`, `lpm_numwords`: threshold for `almost_full`.
- `almost_empty_value`, 1: threshold for `almost_empty`.
- `add_ram_output_register`, `use_eab`, `ram_block_type`, `enable_ecc`, `lpm_type`: accepted for compatibility only; they have no functional effect.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `aclr`  in  1  asynchronous, active-low reset.
- `sclr`  in  1  synchronous clear, active-high; must be tied to 0 when unused.
- `data`  in  `lpm_width`  write data.
- `wrreq`  in  1  write (enqueue) request.
- `rdreq`  in  1  read (dequeue) request.
- `q`  out  `lpm_width`  read data.
- `empty`  out  1  high when the FIFO holds 0 words.
- `full`  out  1  high when the FIFO holds `lpm_numwords` words.
- `usedw`  out  `lpm_widthu`  occupancy count, modulo 2**`lpm_widthu`.
- `almost_full`  out  1  high when occupancy >= `almost_full_value`.
- `almost_empty`  out  1  high when occupancy < `almost_empty_value`.
- `eccstatus`  out  2  constant 2'b00.

## Operation
- Internal state:
  - write pointer and read pointer, each indexing `lpm_numwords` entries, wrapping from `lpm_numwords`-1 to 0;
  - an occupancy counter `lpm_widthu`+1 bits wide;
  - a registered `q`.
- Accepted write: `wrreq` && !(`full` && `overflow_checking`=="ON").
  - Stores `data` at the write pointer; the write pointer advances.
- Accepted read: `rdreq` && !(`empty` && `underflow_checking`=="ON").
  - The read pointer advances.
- The accept decisions use the pre-edge flags:
  - `wrreq` while full is rejected even if `rdreq` is also high;
  - `rdreq` while empty is rejected even if `wrreq` is also high.
- Occupancy update per edge: +1 for a write only, −1 for a read only, unchanged when both or neither are accepted.
- Flags are derived from the registered occupancy:
  - `empty` = (occupancy == 0);
  - `full` = (occupancy == `lpm_numwords`);
  - `usedw` = low `lpm_widthu` bits of occupancy, so it reads 0 when full at depth 2**`lpm_widthu`.
- Normal mode: on an accepted read, `q` loads the head word at that edge. Otherwise `q` holds its value.
- Show-ahead mode:
  - `q` continuously presents the head word whenever `empty`=0; `rdreq` acknowledges it and exposes the next word.
  - While empty, `q` holds its last value.
- With checking "OFF", a violating request is not gated. Resulting contents are unspecified and not verified.
- `sclr`=1 at an edge: pointers and occupancy go to 0; flags take their reset values; `q` is unchanged. `sclr` overrides `wrreq`/`rdreq` in that cycle.

## Timing
- `aclr`=0 asynchronously forces:
  - pointers = 0, occupancy = 0, `q` = 0;
  - `empty`=1, `full`=0, `usedw`=0;
  - `almost_empty` = (`almost_empty_value` > 0), `almost_full` = (`almost_full_value` == 0).
- Reset mid-operation discards all contents. The first edge after `aclr` release is a normal operating edge.
- All flags and `usedw` change on the same edge that accepts the request; there is no extra lag.
  - Example: after a write into an empty FIFO, `empty` falls at that edge.
- Normal mode read latency: 1 cycle from `rdreq` to valid `q`.
- Show-ahead latency: a word written into an empty FIFO appears on `q` in the cycle `empty` falls.
- No combinational path from `wrreq`/`rdreq` to any output.

## Test plan
- Reset values: hold `aclr`=0 → `empty`=1, `full`=0, `usedw`=0, `q`=0. Assert `aclr`=0 with 2 words stored → `empty`=1 immediately, without waiting for a clock edge.
- Fill and drain (normal mode, depth 4): write 0x0011, 0x0022, 0x0033, 0x0044.
  - `full`=1 and `usedw`=0 after the 4th write.
  - Four reads → `q` = 0x0011 … 0x0044, each one cycle after its `rdreq`; `empty`=1 after the last read.
- Overflow and underflow protection:
  - A 5th write of 0x0055 while full is ignored; the drained sequence is unchanged.
  - `rdreq` while empty leaves `q` and `usedw`=0 unchanged.
- Simultaneous requests:
  - With 2 words stored, `wrreq`+`rdreq` together → `usedw` stays 2 and order is preserved.
  - With the FIFO empty, both together → write accepted, `usedw`=1.
- Show-ahead mode: write 0xBEEF into an empty FIFO → `q`=0xBEEF in the same cycle `empty`=0, with no `rdreq` needed. `rdreq` → `empty`=1.
- Pointer wrap-around: across 10 interleaved writes and reads with occupancy kept at 1–3, output order matches input order. `sclr`=1 mid-stream → `empty`=1 and `usedw`=0 at the next edge.
